// File: rtl/spdif_tx_if.sv
// spdif_tx_if: sample-pair handshake between an audio source and spdif_tx.
// The source drives a left/right pair with valid; the transmitter answers ready.
interface spdif_tx_if;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/spdif_tx.sv
// spdif_tx: consumer S/PDIF transmitter, 24-bit stereo, biphase-mark line code.
// Define SPDIF_TX_CHSTAT_EN to send consumer channel status (copy ok, 48 kHz).
module spdif_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       ena,
    spdif_tx_if.slave  s_bus,
    output logic       tx_out,
    output logic       block_start,
    output logic       underrun
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic [DW-1:0] r_div;
    logic [5:0]    r_ui;
    logic          r_sub;
    logic [7:0]    r_frame;
    logic          r_tx;
    logic          r_plvl;
    logic          r_bs;
    logic          r_ur;
    logic          r_ready;
    logic          r_full;
    logic [23:0]   r_hold_l;
    logic [23:0]   r_hold_r;
    logic [23:0]   r_txl;
    logic [23:0]   r_txr;
    logic          r_v;

    logic          w_tick;
    logic          w_fs;
    logic          w_acc;
    logic          w_full_nxt;
    logic [4:0]    w_slot;
    logic          w_c;
    logic [23:0]   w_samp;
    logic          w_par;
    logic [31:0]   w_word;
    logic          w_bit;
    logic [7:0]    w_pre;
    logic          w_ref;
    logic          w_nxt;

    assign w_tick     = (r_div == '0);
    assign w_fs       = w_tick && (r_ui == 6'd0) && !r_sub;
    assign w_acc      = s_bus.sample_valid && r_ready;
    assign w_full_nxt = w_acc || (r_full && !w_fs);
    assign w_slot     = r_ui[5:1];

`ifdef SPDIF_TX_CHSTAT_EN
    // Channel status bit 2 (copy permitted) and bit 25 (48 kHz code 0100).
    assign w_c = (r_frame == 8'd2) || (r_frame == 8'd25);
`else
    assign w_c = 1'b0;
`endif

    assign w_samp = r_sub ? r_txr : r_txl;
    assign w_par  = ^{w_samp, r_v, w_c};
    assign w_word = {w_par, w_c, 1'b0, r_v, w_samp, 4'b0000};
    assign w_bit  = w_word[w_slot];

    always_comb begin
        w_pre = PRE_M;
        if (r_sub)
            w_pre = PRE_W;
        else if (r_frame == 8'd0)
            w_pre = PRE_B;
    end

    // Preamble polarity follows the level of the UI just before it.
    assign w_ref = (r_ui == 6'd0) ? r_tx : r_plvl;

    always_comb begin
        w_nxt = ~r_tx;
        if (w_slot < 5'd4)
            w_nxt = w_pre[~r_ui[2:0]] ^ w_ref;
        else if (r_ui[0])
            w_nxt = r_tx ^ w_bit;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_div    <= '0;
            r_ui     <= '0;
            r_sub    <= 1'b0;
            r_frame  <= '0;
            r_tx     <= 1'b0;
            r_plvl   <= 1'b0;
            r_bs     <= 1'b0;
            r_ur     <= 1'b0;
            r_ready  <= 1'b0;
            r_full   <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_txl    <= '0;
            r_txr    <= '0;
            r_v      <= 1'b1;
        end else if (!ena) begin
            r_div   <= '0;
            r_ui    <= '0;
            r_sub   <= 1'b0;
            r_frame <= '0;
            r_tx    <= 1'b0;
            r_plvl  <= 1'b0;
            r_bs    <= 1'b0;
            r_ur    <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_bs  <= 1'b0;
            r_ur  <= 1'b0;
            r_div <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_tx <= w_nxt;
                r_ui <= r_ui + 6'd1;
                if (r_ui == 6'd0)
                    r_plvl <= r_tx;
                if (r_ui == 6'd63) begin
                    r_sub <= ~r_sub;
                    if (r_sub)
                        r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
                end
            end
            // Old pair leaves the holding register even if a new one lands now.
            if (w_fs) begin
                r_bs  <= (r_frame == 8'd0);
                r_ur  <= ~r_full;
                r_txl <= r_full ? r_hold_l : 24'h000000;
                r_txr <= r_full ? r_hold_r : 24'h000000;
                r_v   <= ~r_full;
            end
            if (w_acc) begin
                r_hold_l <= s_bus.sample_left;
                r_hold_r <= s_bus.sample_right;
            end
            r_full  <= w_full_nxt;
            r_ready <= ~w_full_nxt;
        end
    end

    assign s_bus.sample_ready = r_ready;
    assign tx_out             = r_tx;
    assign block_start        = r_bs;
    assign underrun           = r_ur;
endmodule

// File: doc/spdif_tx.md
SPDIF_TX -- requirements
Module: spdif_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, the number of clk cycles per unit interval (UI, half a bit cell), legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-003 SHALL have port resetb  input  1  reset, synchronous to clk and active-low.
REQ-004 SHALL have port ena  input  1  transmit enable.
REQ-005 SHALL have port sample_left  input  24  left audio sample, two's complement.
REQ-006 SHALL have port sample_right  input  24  right audio sample, two's complement.
REQ-007 SHALL have port sample_valid  input  1  sample pair offered.
REQ-008 SHALL have port sample_ready  output  1  holding register empty, so a pair can be accepted.
REQ-009 SHALL have port tx_out  output  1  biphase-mark (BMC) coded SPDIF line.
REQ-010 SHALL have port block_start  output  1  one-cycle pulse at the start of frame 0 of each block.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-012 SHALL produce a UI strobe every CLK_DIV clk cycles, and tx_out SHALL change only on UI boundaries.
REQ-013 SHALL transmit frames made of two subframes (left, then right), each subframe 32 slots of 2 UI, with blocks of 192 frames (frame counter 0..191, wrapping to 0).
REQ-014 SHALL fill slots 0-3 with the preamble, slots 4-27 with the audio sample LSB first, slot 28 with V, slot 29 with U=0, slot 30 with C, and slot 31 with P.
REQ-015 SHALL set P so that slots 4-31 contain an even number of ones.
REQ-016 SHALL BMC-code slots 4-31: tx_out toggles at the start of every slot and toggles again mid-slot when the bit is 1.
REQ-017 SHALL use preambles, first UI first, for a preceding UI level of 0: B=11101000 (left subframe of frame 0), M=11100010 (other left subframes), W=11100100 (right subframes); the pattern is inverted when the preceding UI level is 1.
REQ-018 SHALL accept a sample pair into the holding register on any cycle with sample_valid && sample_ready; sample_ready SHALL then deassert on the next cycle.
REQ-019 SHALL, on the clk cycle that starts a left preamble, move a full holding register into the transmit shifters and set V=0 for both subframes of that frame.
REQ-020 SHALL, if the holding register is empty at frame start, send 24'h000000 with V=1 in both subframes and pulse underrun.
REQ-021 SHALL give an accept priority over the frame-start transfer when both occur in the same cycle: the old pair transfers, the new pair is held, and sample_ready stays 0.
REQ-022 SHALL pulse block_start on the cycle that starts a B preamble.
REQ-023 SHALL, while ena=0, hold tx_out=0, sample_ready=0 and all counters at their reset values, keep the holding register contents, and start with preamble B of frame 0 on the first UI after ena rises.

Reset
REQ-024 SHALL, on resetb=0 at a clk edge, set tx_out=0, sample_ready=0, block_start=0, underrun=0, the frame counter to 0, the slot and UI counters to 0, and empty the holding register.
REQ-025 SHALL abort any subframe in progress when reset is asserted mid-operation, with no partial completion.
REQ-026 SHALL assert sample_ready on the first cycle after resetb=1 when ena=1.

Configuration
REQ-027 SHALL, when macro SPDIF_TX_CHSTAT_EN is defined, drive C in both subframes of frame n with consumer channel status bit n: bit 2=1 (copy permitted), bits 24-27=4'b0100 (48 kHz), all other bits 0.
REQ-028 SHALL, when SPDIF_TX_CHSTAT_EN is undefined, drive C=0 in every subframe and include no channel-status logic.

Verification
REQ-029 Reset release with ena=1, CLK_DIV=2, no samples -> first 8 UI on tx_out = 11101000 (each UI 2 cycles), block_start pulses once, underrun pulses once, V=1.
REQ-030 Offer left=24'h000001, right=24'h800000 -> after the next preamble, left slot 4 shows a mid-slot toggle, slots 5-27 show none, P=1, V=0; right slot 27 shows a mid-slot toggle.
REQ-031 Keep sample_valid=1 continuously for 193 frames -> no underrun, block_start pulses exactly twice 192 frames apart, preambles follow B, W, M, W, ..., B.
REQ-032 Assert sample_valid on exactly the frame-start cycle with the holding register full -> the old pair is transmitted, the new pair goes out in the next frame, sample_ready=0 until that next frame start.
REQ-033 Assert resetb=0 in the middle of slot 15 -> tx_out=0 on the next cycle, and after release the stream restarts at preamble B of frame 0.
REQ-034 With SPDIF_TX_CHSTAT_EN defined, over 192 frames -> C=1 only in frames 2 and 25; without the macro, C=0 in all frames.
